pc_stack: RTL and testbench
===========================

# pc_stack

Parametrised program counter with a hardware call/return stack, successor to the lab's basic 16-bit load/increment counter. It holds the current instruction address and updates it once per clock by load, signed relative branch, subroutine call, return, or fixed-step increment. Return addresses live in an internal LIFO of configurable depth, with full/empty flags and a sticky error flag. It sits between the instruction fetch path and the control/decode unit of the lab processor datapath.

## Interface
- WIDTH, 16, address width in bits (≥4)
- DEPTH, 8, return-stack entries (≥2, power of two not required)
- STEP, 1, increment amount for `inc` and for the pushed return address
- RESET_VAL, 0, value of `d_o` after reset

- clk  in  1  single clock; all state changes on the rising edge
- res  in  1  one clock; reset is asynchronous and active-low
- d_i  in  WIDTH  load target, call target, or branch offset (two's complement)
- inc  in  1  advance PC by STEP
- load  in  1  PC <= d_i
- branch  in  1  PC <= PC + d_i (signed)
- call  in  1  push PC+STEP, PC <= d_i
- ret  in  1  PC <= top of stack, pop
- d_o  out  WIDTH  current PC (registered)
- depth  out  $clog2(DEPTH+1)  number of valid stack entries
- full  out  1  depth == DEPTH
- empty  out  1  depth == 0
- err  out  1  sticky: set on call-when-full or ret-when-empty

## Operation
- Reset values: d_o=RESET_VAL, depth=0, full=0, empty=1, err=0. Stack storage contents need not be cleared.
- One command per cycle, fixed priority: load > call > ret > branch > inc > hold. Lower-priority inputs asserted in the same cycle are ignored entirely (no side effects).
- load: d_o <= d_i; stack untouched.
- call, not full: stack[depth] <= (d_o + STEP) mod 2^WIDTH; depth+1; d_o <= d_i.
- call, full: d_o, depth, and stack unchanged; err <= 1.
- ret, not empty: d_o <= stack[depth-1]; depth-1.
- ret, empty: d_o and depth unchanged; err <= 1.
- branch: d_o <= (d_o + sign-extended d_i) mod 2^WIDTH; wraps silently, no error.
- inc: d_o <= (d_o + STEP) mod 2^WIDTH; wraps silently (e.g. FFFF -> 0000 for WIDTH=16, STEP=1).
- No command: all state holds.
- err clears only on reset. Once set, it does not block subsequent commands.
- full and empty are decoded from the registered depth, so they are glitch-free.

## Timing
- Every output is registered. A command sampled at edge N is visible on d_o/depth/flags after edge N; latency is 1 cycle.
- Back-to-back commands are legal on consecutive cycles, including call immediately followed by ret, which returns to the caller's PC+STEP.
- Asserting res (low) takes effect immediately, without waiting for clk, even mid-sequence or with a full stack. Deassertion is synchronised by the consumer; the first command is honoured on the first rising edge with res=1.
- Inputs must be stable around the rising edge of clk. No combinational path exists from inputs to outputs.

## Test plan
- Reset/increment: res=0 -> d_o=0000, empty=1, err=0. Release, inc=1 for 3 cycles -> d_o=0001, 0002, 0003. Load d_i=003F -> 003F. Inc -> 0040.
- Wrap: load FFFF, inc -> 0000. Load 0002, branch d_i=FFFC (-4) -> FFFE, with no err.
- Nested calls: from PC 0010, call 0100, then call 0200. Expect depth=2 and d_o=0200. ret -> 0101, depth=1. ret -> 0011, empty=1.
- Overflow/underflow (DEPTH=8): 8 calls -> full=1. A 9th call -> d_o unchanged, depth=8, err=1. Reset, then ret on empty -> d_o unchanged, err=1.
- Priority: load=call=ret=inc=1 with d_i=0055 -> d_o=0055 and depth unchanged. call=ret=1 -> call only. branch=inc=1 with d_i=0004 from 0010 -> 0014.
- Async reset mid-operation: with depth=3 and err=1, pull res low between clock edges -> d_o=RESET_VAL, depth=0, err=0 immediately, before the next edge.

Source files
------------

// File: rtl/pc_stack_if.sv
// Command/status bundle between the control unit (master) and pc_stack (slave).
interface pc_stack_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
);
   localparam int DEPTH_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]   d_i;
   logic               inc;
   logic               load;
   logic               branch;
   logic               call;
   logic               ret;
   logic [WIDTH-1:0]   d_o;
   logic [DEPTH_W-1:0] depth;
   logic               full;
   logic               empty;
   logic               err;

   modport master (
      output d_i, inc, load, branch, call, ret,
      input  d_o, depth, full, empty, err
   );

   modport slave (
      input  d_i, inc, load, branch, call, ret,
      output d_o, depth, full, empty, err
   );
endinterface

// File: rtl/pc_stack.sv
// Program counter with a return-address LIFO: load > call > ret > branch > inc > hold,
// one command per cycle, all outputs registered (1-cycle latency), sticky overflow/underflow error.
module pc_stack #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 8,
   parameter int STEP      = 1,
   parameter int RESET_VAL = 0
) (
   input logic       clk,
   input logic       res,
   pc_stack_if.slave bus
);
   localparam int DEPTH_W = $clog2(DEPTH + 1);
   localparam int IDX_W   = $clog2(DEPTH);

   logic [WIDTH-1:0]   d_o_d, d_o_q;
   logic [DEPTH_W-1:0] depth_d, depth_q;
   logic               err_d, err_q;
   logic [WIDTH-1:0]   stack_q [DEPTH];

   logic               push_en;
   logic [WIDTH-1:0]   push_dat;
   logic [IDX_W-1:0]   push_idx;
   logic [IDX_W-1:0]   top_idx;
   logic               full_w;
   logic               empty_w;

   assign full_w  = (depth_q == DEPTH_W'(DEPTH));
   assign empty_w = (depth_q == '0);

   // Index truncation is safe: a push only happens below DEPTH, a pop only above 0.
   assign push_idx = IDX_W'(depth_q);
   assign top_idx  = IDX_W'(depth_q - DEPTH_W'(1));
   assign push_dat = d_o_q + WIDTH'(STEP);

   always_comb begin
      d_o_d   = d_o_q;
      depth_d = depth_q;
      err_d   = err_q;
      push_en = 1'b0;
      if (bus.load) begin
         d_o_d = bus.d_i;
      end else if (bus.call) begin
         if (full_w) begin
            err_d = 1'b1;
         end else begin
            push_en = 1'b1;
            depth_d = depth_q + DEPTH_W'(1);
            d_o_d   = bus.d_i;
         end
      end else if (bus.ret) begin
         if (empty_w) begin
            err_d = 1'b1;
         end else begin
            depth_d = depth_q - DEPTH_W'(1);
            d_o_d   = stack_q[top_idx];
         end
      end else if (bus.branch) begin
         // Same-width modular add equals adding the sign-extended offset.
         d_o_d = d_o_q + bus.d_i;
      end else if (bus.inc) begin
         d_o_d = d_o_q + WIDTH'(STEP);
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         d_o_q   <= WIDTH'(RESET_VAL);
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         d_o_q   <= d_o_d;
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end

   // Storage needs no reset; depth_q alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_q[push_idx] <= push_dat;
      end
   end

   assign bus.d_o   = d_o_q;
   assign bus.depth = depth_q;
   assign bus.full  = full_w;
   assign bus.empty = empty_w;
   assign bus.err   = err_q;
endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: directed vector table, hand-written overflow/async-reset sequences,
// then random commands against a queue-based reference model.
module tb_pc_stack;
   localparam int WIDTH = 16;
   localparam int DEPTH = 8;

   localparam logic [4:0] CL = 5'b10000;
   localparam logic [4:0] CC = 5'b01000;
   localparam logic [4:0] CR = 5'b00100;
   localparam logic [4:0] CB = 5'b00010;
   localparam logic [4:0] CI = 5'b00001;
   localparam logic [4:0] CN = 5'b00000;

   typedef struct {
      logic [4:0]  cmd;
      logic [15:0] d_i;
      logic [15:0] exp_pc;
      int          exp_depth;
      logic        exp_err;
   } vec_t;

   logic clk;
   logic res;
   int   checks;
   int   errors;

   pc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STEP(1), .RESET_VAL(0)) dut (
      .clk (clk),
      .res (res),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [15:0] pc, input int dep,
                            input logic e);
      chk({tag, "_pc"},    32'(bus.d_o),   32'(pc));
      chk({tag, "_depth"}, 32'(bus.depth), 32'(dep));
      chk({tag, "_full"},  32'(bus.full),  32'(dep == DEPTH));
      chk({tag, "_empty"}, 32'(bus.empty), 32'(dep == 0));
      chk({tag, "_err"},   32'(bus.err),   32'(e));
   endtask

   task automatic apply(input logic [4:0] cmd, input logic [15:0] d);
      {bus.load, bus.call, bus.ret, bus.branch, bus.inc} = cmd;
      bus.d_i = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [4:0] c, input logic [15:0] d,
                               input logic [15:0] pc, input int dep, input logic e);
      vec_t v;
      v.cmd = c; v.d_i = d; v.exp_pc = pc; v.exp_depth = dep; v.exp_err = e;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      logic [15:0] m_pc;
      logic [15:0] m_stk[$];
      logic        m_err;
      logic [4:0]  rc;
      logic [15:0] rd;

      checks = 0;
      errors = 0;
      clk    = 1'b0;
      res    = 1'b0;
      apply(CN, 16'h0000);

      vecs.push_back(mk(CI,           16'h0000, 16'h0001, 0, 1'b0));
      vecs.push_back(mk(CI,           16'h0000, 16'h0002, 0, 1'b0));
      vecs.push_back(mk(CI,           16'h0000, 16'h0003, 0, 1'b0));
      vecs.push_back(mk(CL,           16'h003F, 16'h003F, 0, 1'b0));
      vecs.push_back(mk(CI,           16'h0000, 16'h0040, 0, 1'b0));
      vecs.push_back(mk(CL,           16'hFFFF, 16'hFFFF, 0, 1'b0));
      vecs.push_back(mk(CI,           16'h0000, 16'h0000, 0, 1'b0));
      vecs.push_back(mk(CL,           16'h0002, 16'h0002, 0, 1'b0));
      vecs.push_back(mk(CB,           16'hFFFC, 16'hFFFE, 0, 1'b0));
      vecs.push_back(mk(CL,           16'h0010, 16'h0010, 0, 1'b0));
      vecs.push_back(mk(CC,           16'h0100, 16'h0100, 1, 1'b0));
      vecs.push_back(mk(CC,           16'h0200, 16'h0200, 2, 1'b0));
      vecs.push_back(mk(CR,           16'h0000, 16'h0101, 1, 1'b0));
      vecs.push_back(mk(CR,           16'h0000, 16'h0011, 0, 1'b0));
      vecs.push_back(mk(CL|CC|CR|CI,  16'h0055, 16'h0055, 0, 1'b0));
      vecs.push_back(mk(CC|CR,        16'h0300, 16'h0300, 1, 1'b0));
      vecs.push_back(mk(CR,           16'h0000, 16'h0056, 0, 1'b0));
      vecs.push_back(mk(CL,           16'h0010, 16'h0010, 0, 1'b0));
      vecs.push_back(mk(CB|CI,        16'h0004, 16'h0014, 0, 1'b0));
      vecs.push_back(mk(CC,           16'h0400, 16'h0400, 1, 1'b0));
      vecs.push_back(mk(CR,           16'h0000, 16'h0015, 0, 1'b0));
      vecs.push_back(mk(CN,           16'h1234, 16'h0015, 0, 1'b0));
      vecs.push_back(mk(CR,           16'h0000, 16'h0015, 0, 1'b1));
      vecs.push_back(mk(CI,           16'h0000, 16'h0016, 0, 1'b1));

      #12;
      chk_state("reset", 16'h0000, 0, 1'b0);
      @(negedge clk);
      res = 1'b1;

      foreach (vecs[i]) begin
         apply(vecs[i].cmd, vecs[i].d_i);
         tick();
         chk_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_depth, vecs[i].exp_err);
      end

      // Overflow: fill the stack, then one call too many.
      #2 res = 1'b0;
      #1 chk_state("rst2", 16'h0000, 0, 1'b0);
      @(negedge clk);
      res = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         apply(CC, 16'h1000 + 16'(i));
         tick();
         chk_state($sformatf("fill%0d", i), 16'h1000 + 16'(i), i + 1, 1'b0);
      end
      apply(CC, 16'h2000);
      tick();
      chk_state("ovf", 16'h1007, DEPTH, 1'b1);
      for (int k = 0; k < 5; k++) begin
         apply(CR, 16'h0000);
         tick();
         chk_state($sformatf("pop%0d", k), 16'h1007 - 16'(k), DEPTH - 1 - k, 1'b1);
      end

      // Async reset between edges with depth=3, err=1.
      apply(CN, 16'h0000);
      #3 res = 1'b0;
      #1 chk_state("async", 16'h0000, 0, 1'b0);
      tick();
      chk_state("async_hold", 16'h0000, 0, 1'b0);
      @(negedge clk);
      res = 1'b1;
      apply(CR, 16'h0000);
      tick();
      chk_state("udf", 16'h0000, 0, 1'b1);

      // Random commands against a queue-based model.
      #2 res = 1'b0;
      #1;
      @(negedge clk);
      res   = 1'b1;
      m_pc  = 16'h0000;
      m_err = 1'b0;
      m_stk.delete();
      for (int n = 0; n < 3000; n++) begin
         rc[4] = ($urandom_range(0, 99) < 6);
         rc[3] = ($urandom_range(0, 99) < 30);
         rc[2] = ($urandom_range(0, 99) < 25);
         rc[1] = ($urandom_range(0, 99) < 15);
         rc[0] = ($urandom_range(0, 99) < 30);
         rd    = 16'($urandom);
         apply(rc, rd);
         if (rc[4]) begin
            m_pc = rd;
         end else if (rc[3]) begin
            if (m_stk.size() == DEPTH) m_err = 1'b1;
            else begin
               m_stk.push_back(16'((int'(m_pc) + 1) % 65536));
               m_pc = rd;
            end
         end else if (rc[2]) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else m_pc = m_stk.pop_back();
         end else if (rc[1]) begin
            m_pc = 16'((int'(m_pc) + int'($signed(rd)) + 65536) % 65536);
         end else if (rc[0]) begin
            m_pc = 16'((int'(m_pc) + 1) % 65536);
         end
         tick();
         chk_state($sformatf("rnd%0d", n), m_pc, m_stk.size(), m_err);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
